mem_port_arbiter: RTL and testbench

- Shares the single command port of the `memory` model between the RV32IMA instruction-fetch requester (I) and load/store/AMO requester (D).
- Picks one requester per cycle, registers the command onto the memory's ncs/nwe bus, and routes the read data back with a valid pulse.
- Provides a D-side lock so RV32A read-modify-write sequences reach memory without an interleaved fetch.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_ret_pipe.sv | 26 ++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state, return source, and return tag.
package mem_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_t;

    typedef struct packed {
        logic valid;
        src_t src;
    } ret_tag_t;

endpackage

// File: rtl/mem_arb_ret_pipe.sv
// Two-stage return-tag shift register; stage 1 lines up with read data from memory.
module mem_arb_ret_pipe
    import mem_arb_pkg::*;
(
    input  logic     clk,
    input  logic     nrst,
    input  ret_tag_t tag_i,
    output ret_tag_t tag_o
);

    ret_tag_t stage0_q;
    ret_tag_t stage1_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stage0_q <= '0;
            stage1_q <= '0;
        end else begin
            stage0_q <= tag_i;
            stage1_q <= stage0_q;
        end
    end

    assign tag_o = stage1_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and load/store requesters onto one memory command port,
// with starvation protection for fetch and a bounded D-side lock for atomic sequences.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned LOCK_MAX     = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic                  d_lock,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [DATA_WIDTH-1:0] d_wmask,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  lock_err,
    output logic                  m_ncs,
    output logic                  m_nwe,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [DATA_WIDTH-1:0] m_wmask,
    input  logic [DATA_WIDTH-1:0] m_rdata
);

    localparam int unsigned STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int unsigned LOCK_W   = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);

    arb_state_t            state_q, state_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic [LOCK_W-1:0]     lock_cnt_q, lock_cnt_d;
    logic                  lock_err_q, lock_err_d;
    logic                  m_ncs_q, m_ncs_d;
    logic                  m_nwe_q, m_nwe_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_WIDTH-1:0] m_wmask_q, m_wmask_d;
    ret_tag_t              tag_d, tag_ret;
    logic                  i_prio, lock_exit, lock_timeout;

    assign i_prio       = (starve_q == STARVE_W'(STARVE_LIMIT));
    assign lock_exit    = (state_q == LOCKED) && d_gnt && !d_lock;
    // LOCKED may last at most LOCK_MAX cycles; a real exit in the last cycle wins
    assign lock_timeout = (state_q == LOCKED) && !lock_exit
                          && ((lock_cnt_q + LOCK_W'(1)) == LOCK_W'(LOCK_MAX));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= ARB;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB:     if (d_gnt && d_lock) state_d = LOCKED;
            LOCKED:  if (lock_exit || lock_timeout) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // Grants are combinational accepts for the current cycle
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        unique case (state_q)
            ARB: begin
                i_gnt = i_req && (!d_req || i_prio);
                d_gnt = d_req && !(i_req && i_prio);
            end
            LOCKED:  d_gnt = d_req;
            default: ;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (state_q == ARB) begin
            if (i_gnt || !i_req) starve_d = '0;
            else if (!i_prio)    starve_d = starve_q + STARVE_W'(1);
        end

        lock_cnt_d = lock_cnt_q;
        if (state_q == ARB && d_gnt && d_lock) lock_cnt_d = '0;
        else if (state_q == LOCKED)            lock_cnt_d = lock_cnt_q + LOCK_W'(1);

        lock_err_d = lock_timeout;

        m_ncs_d   = 1'b1;
        m_nwe_d   = 1'b1;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wmask_d = m_wmask_q;
        tag_d     = '0;
        if (d_gnt) begin
            m_ncs_d   = 1'b0;
            m_nwe_d   = !d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_wmask_d = d_wmask;
            tag_d.valid = !d_we;
            tag_d.src   = SRC_D;
        end else if (i_gnt) begin
            m_ncs_d   = 1'b0;
            m_addr_d  = i_addr;
            m_wdata_d = '0;
            m_wmask_d = '0;
            tag_d.valid = 1'b1;
            tag_d.src   = SRC_I;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            starve_q   <= '0;
            lock_cnt_q <= '0;
            lock_err_q <= 1'b0;
            m_ncs_q    <= 1'b1;
            m_nwe_q    <= 1'b1;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_wmask_q  <= '0;
        end else begin
            starve_q   <= starve_d;
            lock_cnt_q <= lock_cnt_d;
            lock_err_q <= lock_err_d;
            m_ncs_q    <= m_ncs_d;
            m_nwe_q    <= m_nwe_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_wmask_q  <= m_wmask_d;
        end
    end

    mem_arb_ret_pipe u_ret_pipe (
        .clk   (clk),
        .nrst  (nrst),
        .tag_i (tag_d),
        .tag_o (tag_ret)
    );

    assign i_rvalid = tag_ret.valid && (tag_ret.src == SRC_I);
    assign d_rvalid = tag_ret.valid && (tag_ret.src == SRC_D);
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;
    assign lock_err = lock_err_q;
    assign m_ncs    = m_ncs_q;
    assign m_nwe    = m_nwe_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_wmask  = m_wmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a read-data stub standing in for the memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        nrst;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt, i_rvalid;
    logic [63:0] i_rdata;
    logic        d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
    logic [31:0] d_addr = '0;
    logic [63:0] d_wdata = '0, d_wmask = '0;
    logic        d_gnt, d_rvalid;
    logic [63:0] d_rdata;
    logic        lock_err, m_ncs, m_nwe;
    logic [31:0] m_addr;
    logic [63:0] m_wdata, m_wmask;
    logic [63:0] m_rdata = '0;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clk(clk), .nrst(nrst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wmask(d_wmask), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .lock_err(lock_err),
        .m_ncs(m_ncs), .m_nwe(m_nwe), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wmask(m_wmask), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Memory stub: read data is the tagged address, one cycle after the read command
    always @(posedge clk) begin
        if (!m_ncs && m_nwe) m_rdata <= {32'hA5A5_0000, m_addr};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst = 1'b1;
        #2 nrst = 1'b0;
        i_req = 1'b1; i_addr = 32'h0000_0111;
        d_req = 1'b1; d_addr = 32'h0000_0222;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ncs", 64'(m_ncs), 64'd1);
        chk("rst_nwe", 64'(m_nwe), 64'd1);
        chk("rst_addr", 64'(m_addr), 64'd0);
        chk("rst_irv", 64'(i_rvalid), 64'd0);
        chk("rst_drv", 64'(d_rvalid), 64'd0);
        chk("rst_lerr", 64'(lock_err), 64'd0);

        // First grant right after reset release
        step();
        nrst = 1'b1; i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        @(negedge clk);
        chk("rel_dgnt", 64'(d_gnt), 64'd1);
        chk("rel_ignt", 64'(i_gnt), 64'd0);
        step();
        d_req = 1'b0;
        @(negedge clk);
        chk("rel_ncs", 64'(m_ncs), 64'd0);
        chk("rel_nwe", 64'(m_nwe), 64'd1);
        chk("rel_addr", 64'(m_addr), 64'h300);
        chk("rel_drv_early", 64'(d_rvalid), 64'd0);
        step();
        @(negedge clk);
        chk("rel_drv", 64'(d_rvalid), 64'd1);
        chk("rel_rdata", d_rdata, 64'hA5A5_0000_0000_0300);
        chk("rel_ncs_idle", 64'(m_ncs), 64'd1);

        // Single fetch
        step();
        i_req = 1'b1; i_addr = 32'h100;
        @(negedge clk);
        chk("if_ignt", 64'(i_gnt), 64'd1);
        chk("if_dgnt", 64'(d_gnt), 64'd0);
        step();
        i_req = 1'b0;
        @(negedge clk);
        chk("if_ncs", 64'(m_ncs), 64'd0);
        chk("if_nwe", 64'(m_nwe), 64'd1);
        chk("if_addr", 64'(m_addr), 64'h100);
        chk("if_irv_early", 64'(i_rvalid), 64'd0);
        step();
        @(negedge clk);
        chk("if_irv", 64'(i_rvalid), 64'd1);
        chk("if_rdata", i_rdata, 64'hA5A5_0000_0000_0100);
        chk("if_drv", 64'(d_rvalid), 64'd0);

        // Contention: D,D,D,D,I repeating; returns follow grant order two cycles later
        step();
        i_req = 1'b1; i_addr = 32'h500;
        d_req = 1'b1; d_addr = 32'h400; d_we = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("ct_ignt", 64'(i_gnt), 64'((k % 5) == 4));
            chk("ct_dgnt", 64'(d_gnt), 64'((k % 5) != 4));
            if (k >= 2) begin
                chk("ct_irv", 64'(i_rvalid), 64'(((k - 2) % 5) == 4));
                chk("ct_drv", 64'(d_rvalid), 64'(((k - 2) % 5) != 4));
                if (((k - 2) % 5) != 4) chk("ct_drdata", d_rdata, 64'hA5A5_0000_0000_0400);
                else                    chk("ct_irdata", i_rdata, 64'hA5A5_0000_0000_0500);
            end
            step();
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("ct_drain_drv", 64'(d_rvalid), 64'd1);
        chk("ct_drain_irv0", 64'(i_rvalid), 64'd0);
        chk("ct_drain_gnt", 64'({i_gnt, d_gnt}), 64'd0);
        step();
        @(negedge clk);
        chk("ct_drain_irv", 64'(i_rvalid), 64'd1);
        chk("ct_drain_irdata", i_rdata, 64'hA5A5_0000_0000_0500);

        // Write
        step();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200;
        d_wdata = 64'hDEAD; d_wmask = 64'hFFFF;
        @(negedge clk);
        chk("wr_dgnt", 64'(d_gnt), 64'd1);
        step();
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("wr_ncs", 64'(m_ncs), 64'd0);
        chk("wr_nwe", 64'(m_nwe), 64'd0);
        chk("wr_addr", 64'(m_addr), 64'h200);
        chk("wr_wdata", m_wdata, 64'hDEAD);
        chk("wr_wmask", m_wmask, 64'hFFFF);
        step();
        @(negedge clk);
        chk("wr_no_drv", 64'(d_rvalid), 64'd0);
        chk("wr_no_irv", 64'(i_rvalid), 64'd0);

        // Lock: locked read, fetch waits until the unlocking write is granted
        step();
        d_req = 1'b1; d_lock = 1'b1; d_addr = 32'h600;
        @(negedge clk);
        chk("lk_dgnt", 64'(d_gnt), 64'd1);
        step();
        d_req = 1'b0; d_lock = 1'b0; i_req = 1'b1; i_addr = 32'h700;
        @(negedge clk);
        chk("lk_ignt1", 64'(i_gnt), 64'd0);
        step();
        @(negedge clk);
        chk("lk_ignt2", 64'(i_gnt), 64'd0);
        chk("lk_drv", 64'(d_rvalid), 64'd1);
        chk("lk_rdata", d_rdata, 64'hA5A5_0000_0000_0600);
        step();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h800;
        @(negedge clk);
        chk("lk_wr_dgnt", 64'(d_gnt), 64'd1);
        chk("lk_wr_ignt", 64'(i_gnt), 64'd0);
        step();
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("lk_after_ignt", 64'(i_gnt), 64'd1);
        chk("lk_after_nwe", 64'(m_nwe), 64'd0);
        chk("lk_after_addr", 64'(m_addr), 64'h800);
        step();
        i_req = 1'b0;
        @(negedge clk);
        chk("lk_no_lerr", 64'(lock_err), 64'd0);

        // Lock timeout: 16 locked cycles, then lock_err with fetch granted
        step();
        d_req = 1'b1; d_lock = 1'b1; d_addr = 32'h900;
        @(negedge clk);
        chk("to_dgnt", 64'(d_gnt), 64'd1);
        step();
        d_req = 1'b0; d_lock = 1'b0; i_req = 1'b1; i_addr = 32'hB00;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            chk("to_hold_ignt", 64'(i_gnt), 64'd0);
            chk("to_hold_lerr", 64'(lock_err), 64'd0);
            step();
        end
        @(negedge clk);
        chk("to_lerr", 64'(lock_err), 64'd1);
        chk("to_ignt", 64'(i_gnt), 64'd1);
        step();
        i_req = 1'b0;
        @(negedge clk);
        chk("to_lerr_once", 64'(lock_err), 64'd0);

        // Exit in the final locked cycle is a normal exit
        step();
        d_req = 1'b1; d_lock = 1'b1; d_addr = 32'hC00;
        @(negedge clk);
        chk("ex_dgnt", 64'(d_gnt), 64'd1);
        step();
        d_req = 1'b0; d_lock = 1'b0; i_req = 1'b1;
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk);
            chk("ex_hold_ignt", 64'(i_gnt), 64'd0);
            step();
        end
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'hD00;
        @(negedge clk);
        chk("ex_last_dgnt", 64'(d_gnt), 64'd1);
        chk("ex_last_ignt", 64'(i_gnt), 64'd0);
        step();
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("ex_no_lerr", 64'(lock_err), 64'd0);
        chk("ex_ignt", 64'(i_gnt), 64'd1);

        // Reset mid-transfer drops the in-flight fetch
        step();
        i_addr = 32'hA00;
        @(negedge clk);
        chk("mr_ignt", 64'(i_gnt), 64'd1);
        step();
        nrst = 1'b0; i_req = 1'b0;
        @(negedge clk);
        chk("mr_ncs", 64'(m_ncs), 64'd1);
        chk("mr_irv0", 64'(i_rvalid), 64'd0);
        step();
        nrst = 1'b1;
        @(negedge clk);
        chk("mr_irv1", 64'(i_rvalid), 64'd0);
        step();
        @(negedge clk);
        chk("mr_irv2", 64'(i_rvalid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
